// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared types and constants for the I2C target
// Purpose: state encoding, ACK/NACK bit values, register-address byte-count bound.
// Ports: none (package).
package iic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } iic_state_t;

  localparam logic IIC_ACK  = 1'b0;
  localparam logic IIC_NACK = 1'b1;

  // Only 1 or 2 pointer bytes make sense; anything else falls back to 2.
  function automatic logic [1:0] addr_bytes_clamp(input logic [1:0] n);
    return (n == 2'd1) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/iic_line_sync.sv
// rtl/iic_line_sync.sv - SCL/SDA synchronizer and bus-condition detector
// Purpose: 2-FF synchronizers plus one history stage for edge/START/STOP pulses.
// Ports:
//   clk, rstn           - system clock, async active-low reset
//   scl, sda_in         - raw bus pins
//   sda_s               - synchronized SDA level
//   scl_rise, scl_fall  - single-cycle SCL edge pulses
//   start_det, stop_det - single-cycle START / STOP pulses
module iic_line_sync (
  input  logic clk,
  input  logic rstn,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_m, scl_s, scl_d;
  logic sda_m, sda_d;

  // Idle bus is high, so reset every stage to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_d <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= sda_in;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  // SCL must be high both before and after the SDA edge to qualify.
  assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/iic_slave_driver.sv
// rtl/iic_slave_driver.sv - I2C target with 8/16-bit register pointer and 8-bit data
// Purpose: decodes START/STOP/device/pointer/data and drives a local register port.
// Ports:
//   clk, rstn                        - system clock, async active-low reset
//   scl, sda_in                      - bus pins (raw)
//   sda_out, sda_out_en              - open-drain SDA drive (sda_out is always 0)
//   reg_addr                         - register pointer
//   reg_wr_en, reg_wr_data           - one-cycle write strobe and data
//   reg_rd_en, reg_rd_data           - one-cycle read request, data valid 1 clk later
//   busy                             - START..STOP window
//   byte_over                        - pulse after each ACK/NACK clock
module iic_slave_driver
  import iic_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID = 8'h56,
  parameter logic [1:0] ADDR_BYTE = 2'd2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_out,
  output logic        sda_out_en,
  output logic [15:0] reg_addr,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wr_data,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rd_data,
  output logic        busy,
  output logic        byte_over
);

  localparam logic [1:0] NB = addr_bytes_clamp(ADDR_BYTE);

  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  iic_state_t state;
  logic [3:0] bit_cnt;
  logic [7:0] rx_sh, tx_sh, rx_byte;
  logic [1:0] addr_cnt;
  logic       rw, rx_ack, rd_pend;
  logic [15:0] next_addr;

  iic_line_sync u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda_out   = 1'b0;
  assign rx_byte   = {rx_sh[6:0], sda_s};
  // Single-byte pointers wrap within the low byte.
  assign next_addr = (NB == 2'd1) ? {8'h00, reg_addr[7:0] + 8'd1} : reg_addr + 16'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      bit_cnt     <= 4'd0;
      rx_sh       <= 8'h00;
      tx_sh       <= 8'h00;
      addr_cnt    <= 2'd0;
      rw          <= 1'b0;
      rx_ack      <= 1'b0;
      rd_pend     <= 1'b0;
      sda_out_en  <= 1'b0;
      reg_addr    <= 16'h0000;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= 8'h00;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      byte_over   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      byte_over <= 1'b0;
      // Register file answers one cycle after the request.
      rd_pend   <= reg_rd_en;
      if (rd_pend) tx_sh <= reg_rd_data;

      // Bus conditions win over any data edge seen in the same cycle.
      if (start_det) begin
        state      <= ST_DEV;
        bit_cnt    <= 4'd0;
        sda_out_en <= 1'b0;
        busy       <= 1'b1;
      end else if (stop_det) begin
        state      <= ST_IDLE;
        sda_out_en <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_DEV: begin
            if (scl_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              rw <= rx_sh[0];
              if (rx_sh[7:1] == DEVICE_ID[7:1]) begin
                sda_out_en <= 1'b1;
                state      <= ST_DEV_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_DEV_ACK: begin
            if (scl_rise && rw) begin
              reg_rd_en <= 1'b1;
            end else if (scl_fall) begin
              sda_out_en <= rw ? ~tx_sh[7] : 1'b0;
              bit_cnt    <= 4'd0;
              addr_cnt   <= 2'd0;
              byte_over  <= 1'b1;
              state      <= rw ? ST_RDATA : ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (scl_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              reg_addr   <= (NB == 2'd1) ? {8'h00, rx_sh} : {reg_addr[7:0], rx_sh};
              addr_cnt   <= addr_cnt + 2'd1;
              sda_out_en <= 1'b1;
              state      <= ST_ADDR_ACK;
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              sda_out_en <= 1'b0;
              bit_cnt    <= 4'd0;
              byte_over  <= 1'b1;
              state      <= (addr_cnt == NB) ? ST_WDATA : ST_ADDR;
            end
          end
          ST_WDATA: begin
            if (scl_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                reg_wr_en   <= 1'b1;
                reg_wr_data <= rx_byte;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_out_en <= 1'b1;
              state      <= ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_out_en <= 1'b0;
              reg_addr   <= next_addr;
              bit_cnt    <= 4'd0;
              byte_over  <= 1'b1;
              state      <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            // The MSB was put on the bus when this state was entered.
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_out_en <= 1'b0;
                state      <= ST_RACK;
              end else begin
                sda_out_en <= ~tx_sh[6];
                tx_sh      <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          ST_RACK: begin
            if (scl_rise) begin
              rx_ack <= (sda_s == IIC_ACK);
              if (sda_s == IIC_ACK) begin
                reg_addr  <= next_addr;
                reg_rd_en <= 1'b1;
              end
            end else if (scl_fall) begin
              byte_over <= 1'b1;
              bit_cnt   <= 4'd0;
              if (rx_ack) begin
                sda_out_en <= ~tx_sh[7];
                state      <= ST_RDATA;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_IDLE, ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_slave_driver.sv
// tb/tb_iic_slave_driver.sv - directed bench for iic_slave_driver
`timescale 1ns/1ps
module tb_iic_slave_driver;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic scl_m = 1'b1;
  logic m_low = 1'b0;
  logic sda;

  logic        out1, en1, wr_en1, rd_en1, busy1, bo1;
  logic [15:0] addr1;
  logic [7:0]  wdata1, rd_data1;
  logic        out2, en2, wr_en2, rd_en2, busy2, bo2;
  logic [15:0] addr2;
  logic [7:0]  wdata2;
  logic [7:0]  rd_data2 = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] wr1_q[$];
  logic [23:0] wr2_q[$];
  logic [15:0] rd1_q[$];
  int bo1_cnt = 0;
  bit en_seen = 0;

  always #50 clk = ~clk;

  assign sda = (~m_low) & (en1 ? out1 : 1'b1) & (en2 ? out2 : 1'b1);

  iic_slave_driver #(.DEVICE_ID(8'h56), .ADDR_BYTE(2'd2)) u_dut (
    .clk(clk), .rstn(rstn), .scl(scl_m), .sda_in(sda),
    .sda_out(out1), .sda_out_en(en1), .reg_addr(addr1),
    .reg_wr_en(wr_en1), .reg_wr_data(wdata1),
    .reg_rd_en(rd_en1), .reg_rd_data(rd_data1),
    .busy(busy1), .byte_over(bo1)
  );

  iic_slave_driver #(.DEVICE_ID(8'h3C), .ADDR_BYTE(2'd1)) u_dut1b (
    .clk(clk), .rstn(rstn), .scl(scl_m), .sda_in(sda),
    .sda_out(out2), .sda_out_en(en2), .reg_addr(addr2),
    .reg_wr_en(wr_en2), .reg_wr_data(wdata2),
    .reg_rd_en(rd_en2), .reg_rd_data(rd_data2),
    .busy(busy2), .byte_over(bo2)
  );

  function automatic logic [7:0] rf(input logic [15:0] a);
    case (a)
      16'h0010: return 8'h5A;
      16'h0011: return 8'hC3;
      default:  return 8'hEE;
    endcase
  endfunction

  always @(posedge clk) if (rd_en1) rd_data1 <= rf(addr1);

  always @(negedge clk) begin
    if (wr_en1) wr1_q.push_back({addr1, wdata1});
    if (wr_en2) wr2_q.push_back({addr2, wdata2});
    if (rd_en1) rd1_q.push_back(addr1);
    if (bo1) bo1_cnt++;
    if (en1 || en2) en_seen = 1;
  end

  task automatic clock_bit(input logic b, output logic r);
    #625 m_low = ~b;
    #625 scl_m = 1'b1;
    #625 r = sda;
    #625 scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    #625 m_low = 1'b0;
    #625 scl_m = 1'b1;
    #625 m_low = 1'b1;
    #625 scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #625 m_low = 1'b1;
    #625 scl_m = 1'b1;
    #625 m_low = 1'b0;
    #625;
  endtask

  task automatic wb(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rb(input logic mack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clock_bit(~mack, r);
  endtask

  task automatic test_reset();
    #300;
    n_cmp++; if ({out1, en1, wr_en1, rd_en1, busy1, bo1, addr1, wdata1} !== 30'd0) begin n_bad++; $display("FAIL reset_in: got %h expected 0", {out1, en1, wr_en1, rd_en1, busy1, bo1, addr1, wdata1}); end
    rstn = 1'b1;
    #300;
    n_cmp++; if ({en1, busy1, addr1, en2, busy2, addr2} !== 36'd0) begin n_bad++; $display("FAIL reset_out: got %h expected 0", {en1, busy1, addr1, en2, busy2, addr2}); end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    wr1_q.delete(); wr2_q.delete(); bo1_cnt = 0;
    i2c_start();
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL wr_busy_hi: got %b expected 1", busy1); end
    wb(8'h56, a0); wb(8'h12, a1); wb(8'h34, a2); wb(8'hA5, a3);
    i2c_stop();
    #500;
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_bad++; $display("FAIL wr_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    n_cmp++; if (wr1_q.size() !== 1) begin n_bad++; $display("FAIL wr_count: got %0d expected 1", wr1_q.size()); end
    if (wr1_q.size() >= 1) begin
      n_cmp++; if (wr1_q[0] !== 24'h1234A5) begin n_bad++; $display("FAIL wr_entry: got %h expected 1234a5", wr1_q[0]); end
    end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL wr_busy_lo: got %b expected 0", busy1); end
    n_cmp++; if (bo1_cnt !== 4) begin n_bad++; $display("FAIL wr_byte_over: got %0d expected 4", bo1_cnt); end
    n_cmp++; if (addr1 !== 16'h1235) begin n_bad++; $display("FAIL wr_ptr: got %h expected 1235", addr1); end
    n_cmp++; if (wr2_q.size() !== 0) begin n_bad++; $display("FAIL wr_other_dev: got %0d expected 0", wr2_q.size()); end
  endtask

  task automatic test_burst_write();
    logic a;
    logic [5:0] acks;
    logic [7:0] bytes [6];
    bytes = '{8'h56, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03};
    wr1_q.delete();
    i2c_start();
    for (int i = 0; i < 6; i++) begin
      wb(bytes[i], a);
      acks[i] = a;
    end
    i2c_stop();
    #500;
    n_cmp++; if (acks !== 6'b111111) begin n_bad++; $display("FAIL burst_acks: got %b expected 111111", acks); end
    n_cmp++; if (wr1_q.size() !== 3) begin n_bad++; $display("FAIL burst_count: got %0d expected 3", wr1_q.size()); end
    if (wr1_q.size() == 3) begin
      n_cmp++; if (wr1_q[0] !== 24'hFFFF01) begin n_bad++; $display("FAIL burst_w0: got %h expected ffff01", wr1_q[0]); end
      n_cmp++; if (wr1_q[1] !== 24'h000002) begin n_bad++; $display("FAIL burst_w1_wrap: got %h expected 000002", wr1_q[1]); end
      n_cmp++; if (wr1_q[2] !== 24'h000103) begin n_bad++; $display("FAIL burst_w2: got %h expected 000103", wr1_q[2]); end
    end
  endtask

  task automatic test_random_read();
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1;
    wr1_q.delete(); rd1_q.delete();
    i2c_start();
    wb(8'h56, a0); wb(8'h00, a1); wb(8'h10, a2);
    i2c_start();
    wb(8'h57, a3);
    rb(1'b1, d0);
    rb(1'b0, d1);
    i2c_stop();
    #500;
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_bad++; $display("FAIL rd_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    n_cmp++; if (d0 !== 8'h5A) begin n_bad++; $display("FAIL rd_byte0: got %h expected 5a", d0); end
    n_cmp++; if (d1 !== 8'hC3) begin n_bad++; $display("FAIL rd_byte1: got %h expected c3", d1); end
    n_cmp++; if (rd1_q.size() !== 2) begin n_bad++; $display("FAIL rd_count: got %0d expected 2", rd1_q.size()); end
    if (rd1_q.size() == 2) begin
      n_cmp++; if (rd1_q[0] !== 16'h0010) begin n_bad++; $display("FAIL rd_addr0: got %h expected 0010", rd1_q[0]); end
      n_cmp++; if (rd1_q[1] !== 16'h0011) begin n_bad++; $display("FAIL rd_addr1: got %h expected 0011", rd1_q[1]); end
    end
    n_cmp++; if (wr1_q.size() !== 0) begin n_bad++; $display("FAIL rd_no_write: got %0d expected 0", wr1_q.size()); end
  endtask

  task automatic test_wrong_device();
    logic a, b;
    wr1_q.delete(); wr2_q.delete(); rd1_q.delete();
    en_seen = 0;
    i2c_start();
    wb(8'h58, a);
    wb(8'h11, b);
    i2c_stop();
    #500;
    n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL wd_nack: got ack=%b expected 0", a); end
    n_cmp++; if (en_seen !== 1'b0) begin n_bad++; $display("FAIL wd_sda_driven: got %b expected 0", en_seen); end
    n_cmp++; if (wr1_q.size() + wr2_q.size() + rd1_q.size() !== 0) begin n_bad++; $display("FAIL wd_strobes: got %0d expected 0", wr1_q.size() + wr2_q.size() + rd1_q.size()); end
    i2c_start();
    wb(8'h56, a);
    i2c_stop();
    #500;
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL wd_next_ack: got ack=%b expected 1", a); end
  endtask

  task automatic test_addr_byte1();
    logic a0, a1, a2;
    wr1_q.delete(); wr2_q.delete();
    i2c_start();
    wb(8'h3C, a0); wb(8'h7F, a1); wb(8'h11, a2);
    i2c_stop();
    #500;
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_bad++; $display("FAIL ab1_acks: got %b expected 111", {a0, a1, a2}); end
    n_cmp++; if (wr2_q.size() !== 1) begin n_bad++; $display("FAIL ab1_count: got %0d expected 1", wr2_q.size()); end
    if (wr2_q.size() >= 1) begin
      n_cmp++; if (wr2_q[0] !== 24'h007F11) begin n_bad++; $display("FAIL ab1_entry: got %h expected 007f11", wr2_q[0]); end
    end
    n_cmp++; if (addr2 !== 16'h0080) begin n_bad++; $display("FAIL ab1_ptr: got %h expected 0080", addr2); end
    n_cmp++; if (wr1_q.size() !== 0) begin n_bad++; $display("FAIL ab1_other_dev: got %0d expected 0", wr1_q.size()); end
  endtask

  task automatic test_abort();
    logic a0, a1, a2, r;
    wr1_q.delete(); rd1_q.delete();
    i2c_start();
    wb(8'h56, a0); wb(8'h00, a1); wb(8'h20, a2);
    clock_bit(1'b1, r); clock_bit(1'b0, r); clock_bit(1'b1, r); clock_bit(1'b0, r);
    i2c_stop();
    #500;
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_bad++; $display("FAIL ab_acks: got %b expected 111", {a0, a1, a2}); end
    n_cmp++; if (wr1_q.size() !== 0) begin n_bad++; $display("FAIL ab_no_write: got %0d expected 0", wr1_q.size()); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL ab_idle: got busy=%b expected 0", busy1); end
    n_cmp++; if (addr1 !== 16'h0020) begin n_bad++; $display("FAIL ab_ptr: got %h expected 0020", addr1); end
    i2c_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'h56 >> i) & 8'h01) != 8'h00, r);
    #625;
    n_cmp++; if (en1 !== 1'b1) begin n_bad++; $display("FAIL rst_ack_drive: got %b expected 1", en1); end
    rstn = 1'b0;
    #20;
    n_cmp++; if (en1 !== 1'b0) begin n_bad++; $display("FAIL rst_release: got %b expected 0", en1); end
    #200;
    rstn = 1'b1;
    i2c_stop();
    #500;
    n_cmp++; if ({addr1, busy1} !== 17'd0) begin n_bad++; $display("FAIL rst_state: got %h expected 0", {addr1, busy1}); end
    n_cmp++; if (wr1_q.size() + rd1_q.size() !== 0) begin n_bad++; $display("FAIL rst_strobes: got %0d expected 0", wr1_q.size() + rd1_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_write();
    test_random_read();
    test_wrong_device();
    test_addr_byte1();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
